// File: rtl/bsg_link_pkg.sv
// Shared constants and types for the bsg upstream link: word/byte geometry, tx FSM states
// and the default credit configuration.
package bsg_link_pkg;

  localparam int unsigned IO_W                = 8;
  localparam int unsigned CORE_W              = 32;
  localparam int unsigned BYTES_PER_WORD      = 4;
  localparam int unsigned BYTE_IDX_W          = 2;
  localparam int unsigned CREDIT_INIT_DEF     = 128;
  localparam int unsigned CREDIT_PER_EDGE_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  // Core word viewed as bytes; index 0 is bits [7:0] and goes out first.
  typedef logic [BYTES_PER_WORD-1:0][IO_W-1:0] core_word_t;

endpackage

// File: rtl/bsg_link_word_fifo.sv
// Word FIFO with in-place head peek. Pointers carry an extra wrap bit so that
// full and empty can be told apart without a separate counter.
module bsg_link_word_fifo
  import bsg_link_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = CORE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Pointer advance; caller guarantees no push while full and no pop while empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/bsg_upstream_channel_tx.sv
// Upstream transmit stage: buffers 32-bit core words and serialises them low byte first
// onto the 8-bit io link, gated by credit returned as edges on io_token_in.
module bsg_upstream_channel_tx
  import bsg_link_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned CREDIT_INIT     = CREDIT_INIT_DEF,
  parameter int unsigned CREDIT_PER_EDGE = CREDIT_PER_EDGE_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_valid_in,
  input  logic [CORE_W-1:0] core_data_in,
  output logic              core_ready_out,
  output logic              io_valid_out,
  output logic [IO_W-1:0]   io_data_out,
  input  logic              io_token_in,
  output logic              credit_err
);

  localparam int unsigned CREDIT_W = $clog2(CREDIT_INIT + 1);
  localparam int unsigned SUM_W    = CREDIT_W + 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  tx_state_e             state_q, state_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic                  io_valid_q, io_valid_d;
  logic [IO_W-1:0]       io_data_q, io_data_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  credit_err_q, credit_err_d;
  logic                  tok_q;

  logic                  tok_edge;
  logic                  send;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CORE_W-1:0]     fifo_head;
  core_word_t            head_word;
  logic [SUM_W-1:0]      credit_sum;

  assign push           = core_valid_in & ~fifo_full;
  assign core_ready_out = ~fifo_full;
  assign head_word      = fifo_head;
  assign tok_edge       = io_token_in ^ tok_q;

  bsg_link_word_fifo #(
    .DEPTH (DEPTH),
    .W     (CORE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (core_data_in),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Serialiser FSM: next state, byte index, and the registered io byte.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    io_valid_d = 1'b0;
    io_data_d  = io_data_q;
    send       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d    = SEND;
          byte_idx_d = '0;
        end
      end
      SEND: begin
        if (credit_q != '0) begin
          send       = 1'b1;
          io_valid_d = 1'b1;
          io_data_d  = head_word[byte_idx_q];
          if (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1)) begin
            // Last byte frees the head; a same-cycle push keeps the stream gap-free.
            pop        = 1'b1;
            byte_idx_d = '0;
            state_d    = ((fifo_count > CNT_W'(1)) || push) ? SEND : IDLE;
          end else begin
            byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit: add on token edge, subtract on send, clamp and flag on overflow.
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    credit_sum   = SUM_W'(credit_q)
                 + (tok_edge ? SUM_W'(CREDIT_PER_EDGE) : SUM_W'(0))
                 - (send ? SUM_W'(1) : SUM_W'(0));
    if (credit_sum > SUM_W'(CREDIT_INIT)) begin
      credit_d     = CREDIT_W'(CREDIT_INIT);
      credit_err_d = 1'b1;
    end else begin
      credit_d = credit_sum[CREDIT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      io_valid_q   <= 1'b0;
      io_data_q    <= '0;
      credit_q     <= CREDIT_W'(CREDIT_INIT);
      credit_err_q <= 1'b0;
      tok_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      io_valid_q   <= io_valid_d;
      io_data_q    <= io_data_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      tok_q        <= io_token_in;
    end
  end

  assign io_valid_out = io_valid_q;
  assign io_data_out  = io_data_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_bsg_upstream_channel_tx.sv
// Scoreboard bench for bsg_upstream_channel_tx: accepted words become expected bytes,
// a byte-level credit model and an occupancy model check every cycle.
module tb_bsg_upstream_channel_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_valid_in = 1'b0;
  logic [31:0] core_data_in = '0;
  logic        core_ready_out;
  logic        io_valid_out;
  logic [7:0]  io_data_out;
  logic        io_token_in = 1'b0;
  logic        credit_err;

  bsg_upstream_channel_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .core_valid_in  (core_valid_in),
    .core_data_in   (core_data_in),
    .core_ready_out (core_ready_out),
    .io_valid_out   (io_valid_out),
    .io_data_out    (io_data_out),
    .io_token_in    (io_token_in),
    .credit_err     (credit_err)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         vcyc_q[$];
  int         acc_words = 0;
  int         acc_cyc = 0;
  int         sent = 0;
  int         cred_m = 128;
  bit         err_m = 1'b0;
  bit         prev_tok = 1'b0;
  bit         tok_edge_s = 1'b0;
  bit         prev_v = 1'b0;
  int         pend_prev = 0;
  bit         saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: posedge samples accepts/token, negedge checks the registered outputs.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_words  = 0;
      prev_tok   = 1'b0;
      tok_edge_s = 1'b0;
    end else begin
      tok_edge_s = io_token_in ^ prev_tok;
      prev_tok   = io_token_in;
      if (core_valid_in && core_ready_out) begin
        acc_words++;
        acc_cyc = cyc;
        for (int i = 0; i < 4; i++) exp_q.push_back(core_data_in[8*i +: 8]);
      end
    end
    @(negedge clk);
    if (!rst_n) begin
      cred_m    = 128;
      err_m     = 1'b0;
      sent      = 0;
      prev_v    = 1'b0;
      pend_prev = 0;
      saw_full  = 1'b0;
      vcyc_q.delete();
    end else begin
      int nc;
      if (prev_v && pend_prev > 0 && cred_m != 0) chk("no_gap", io_valid_out, 1);
      if (io_valid_out) begin
        chk("credit_avail", (cred_m != 0), 1);
        chk("byte_pending", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("byte_data", io_data_out, exp_q.pop_front());
        sent++;
        vcyc_q.push_back(cyc);
      end
      nc = cred_m + (tok_edge_s ? 16 : 0) - (io_valid_out ? 1 : 0);
      if (nc > 128) begin
        nc    = 128;
        err_m = 1'b1;
      end
      cred_m = nc;
      chk("credit_err", credit_err, err_m);
      chk("ready", core_ready_out, ((acc_words - sent / 4) < 4));
      if (!core_ready_out) saw_full = 1'b1;
      prev_v    = io_valid_out;
      pend_prev = exp_q.size();
    end
  end

  task automatic do_reset();
    rst_n         = 1'b0;
    core_valid_in = 1'b0;
    io_token_in   = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_word(input logic [31:0] d);
    bit done = 1'b0;
    for (int k = 0; k < 600 && !done; k++) begin
      @(negedge clk);
      core_valid_in = 1'b1;
      core_data_in  = d;
      if (core_ready_out) done = 1'b1;
      @(posedge clk);
    end
    chk("push_accepted", done, 1);
  endtask

  task automatic idle_in();
    @(negedge clk);
    core_valid_in = 1'b0;
  endtask

  task automatic push_burst(input int n);
    for (int i = 0; i < n; i++) push_word($urandom);
    idle_in();
  endtask

  initial begin
    int span;
    int start;
    bit seen;

    // 1: reset holds outputs while inputs toggle randomly
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      core_valid_in = 1'($urandom);
      core_data_in  = $urandom;
      io_token_in   = 1'($urandom);
      #1;
      chk("rst_valid", io_valid_out, 0);
      chk("rst_data", io_data_out, 0);
      chk("rst_ready", core_ready_out, 1);
      chk("rst_err", credit_err, 0);
      chk("rst_credit", dut.credit_q, 128);
    end
    do_reset();

    // 2: single word latency and byte order
    push_word(32'hDDCCBBAA);
    idle_in();
    repeat (8) @(negedge clk);
    #1;
    chk("t2_count", vcyc_q.size(), 4);
    if (vcyc_q.size() == 4) begin
      chk("t2_first_cyc", vcyc_q[0], acc_cyc + 2);
      chk("t2_last_cyc", vcyc_q[3], acc_cyc + 5);
    end
    chk("t2_idle", io_valid_out, 0);
    chk("t2_ready", core_ready_out, 1);

    // 3: five back-to-back words stream with no gaps
    start = vcyc_q.size();
    push_burst(5);
    repeat (30) @(negedge clk);
    #1;
    chk("t3_count", vcyc_q.size(), start + 20);
    span = (vcyc_q.size() == start + 20) ? vcyc_q[start + 19] - vcyc_q[start] : -1;
    chk("t3_span", span, 19);
    chk("t3_saw_full", saw_full, 1);

    // 4: starvation at 128 bytes, each token edge releases 16 more
    do_reset();
    fork
      push_burst(40);
    join_none
    repeat (220) @(negedge clk);
    #1;
    chk("t4_starved", sent, 128);
    chk("t4_stalled", io_valid_out, 0);
    io_token_in = ~io_token_in;
    repeat (40) @(negedge clk);
    #1;
    chk("t4_after_edge1", sent, 144);
    io_token_in = ~io_token_in;
    repeat (40) @(negedge clk);
    #1;
    chk("t4_after_edge2", sent, 160);
    wait fork;
    chk("t4_drained", exp_q.size(), 0);

    // 5: token edge coinciding with the send at credit 1
    do_reset();
    fork
      push_burst(36);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (sent == 127) seen = 1'b1;
    end
    chk("t5_reached_127", seen, 1);
    io_token_in = ~io_token_in;
    @(negedge clk);
    #1;
    chk("t5_credit16", dut.credit_q, 16);
    repeat (40) @(negedge clk);
    #1;
    wait fork;
    chk("t5_count", vcyc_q.size(), 144);
    span = (vcyc_q.size() == 144) ? vcyc_q[143] - vcyc_q[0] : -1;
    chk("t5_span", span, 143);

    // 6: overflow at full credit, then async reset mid-word
    do_reset();
    io_token_in = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_err_set", credit_err, 1);
    chk("t6_credit_clamp", dut.credit_q, 128);
    push_word(32'h44332211);
    idle_in();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (io_valid_out) seen = 1'b1;
    end
    chk("t6_valid_seen", seen, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", io_valid_out, 0);
    chk("t6_async_err", credit_err, 0);
    chk("t6_async_ready", core_ready_out, 1);
    io_token_in = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_discarded", sent, 0);
    chk("t6_err_clear", credit_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
